// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit driving one Wishbone classic-cycle transaction per request
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  done_o,
  output logic                  misalign_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_we_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] size_q, off_q;
  logic uns_q, accept, mis;
  logic [DATA_WIDTH-1:0] lane, ext;
  assign req_ready_o = state == IDLE;
  assign accept = req_ready_o && req_valid_i;
  assign mis = req_size_i == 2'b11 || (req_size_i == 2'b01 && req_addr_i[0]) ||
               (req_size_i == 2'b10 && |req_addr_i[1:0]);
  assign lane = wb_dat_i >> {off_q, 3'b000};
  assign ext = size_q == 2'b00 ? {{(DATA_WIDTH-8){~uns_q & lane[7]}}, lane[7:0]} :
               size_q == 2'b01 ? {{(DATA_WIDTH-16){~uns_q & lane[15]}}, lane[15:0]} : lane;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (mis ? DONE : ACCESS) : IDLE;
      ACCESS:  state_nx = wb_ack_i ? DONE : ACCESS;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      size_q     <= '0;
      off_q      <= '0;
      uns_q      <= 1'b0;
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
      rdata_o    <= '0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
    end else begin
      state  <= state_nx;
      done_o <= 1'b0;
      if (accept) begin
        size_q     <= req_size_i;
        off_q      <= req_addr_i[1:0];
        uns_q      <= req_unsigned_i;
        wb_cyc_o   <= ~mis;
        wb_stb_o   <= ~mis;
        wb_we_o    <= req_we_i & ~mis;
        wb_adr_o   <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
        wb_dat_o   <= req_wdata_i << {req_addr_i[1:0], 3'b000};
        wb_sel_o   <= req_size_i == 2'b00 ? 4'b0001 << req_addr_i[1:0] :
                      req_size_i == 2'b01 ? 4'b0011 << req_addr_i[1:0] : 4'b1111;
        done_o     <= mis;
        misalign_o <= mis;
        if (mis) rdata_o <= '0;
      end
      // the ack edge ends the bus cycle and publishes the extended load data
      if (state == ACCESS && wb_ack_i) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
        done_o   <= 1'b1;
        rdata_o  <= wb_we_o ? '0 : ext;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of load/store alignment, latency, misalign, reset and back-to-back
module tb_mem_access_unit;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_unsigned_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0, wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        req_ready_o, done_o, misalign_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] rdata_o, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  int checks = 0, failures = 0;

  mem_access_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .done_o(done_o), .misalign_o(misalign_o),
    .rdata_o(rdata_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic ack_with(input logic [31:0] d);
    wb_ack_i = 1'b1; wb_dat_i = d;
    tick();
    wb_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready_o); end
    checks++; if ({done_o, misalign_o, wb_cyc_o, wb_stb_o, wb_we_o} !== 5'b0) begin failures++; $display("FAIL rst_ctl got=%b exp=00000", {done_o, misalign_o, wb_cyc_o, wb_stb_o, wb_we_o}); end
    checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o, rdata_o} !== 100'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {wb_adr_o, wb_dat_o, wb_sel_o, rdata_o}); end
  endtask

  task automatic test_lb();
    for (int u = 0; u < 2; u++) begin
      issue(1'b0, 2'b00, u[0], 32'h80000003, 32'h0);
      checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b110_1000) begin failures++; $display("FAIL lb_bus got=%b exp=1101000", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
      checks++; if (wb_adr_o !== 32'h80000000) begin failures++; $display("FAIL lb_adr got=%h exp=80000000", wb_adr_o); end
      tick(); tick();
      checks++; if ({wb_cyc_o, wb_stb_o, done_o, req_ready_o} !== 4'b1100) begin failures++; $display("FAIL lb_wait got=%b exp=1100", {wb_cyc_o, wb_stb_o, done_o, req_ready_o}); end
      ack_with(32'h80FF1234);
      checks++; if ({done_o, misalign_o, wb_cyc_o, wb_stb_o} !== 4'b1000) begin failures++; $display("FAIL lb_done got=%b exp=1000", {done_o, misalign_o, wb_cyc_o, wb_stb_o}); end
      checks++; if (rdata_o !== (u ? 32'h00000080 : 32'hFFFFFF80)) begin failures++; $display("FAIL lb_rdata u=%0d got=%h exp=%h", u, rdata_o, u ? 32'h00000080 : 32'hFFFFFF80); end
      tick();
      checks++; if ({done_o, req_ready_o} !== 2'b01) begin failures++; $display("FAIL lb_pulse got=%b exp=01", {done_o, req_ready_o}); end
    end
  endtask

  task automatic test_lh();
    int lat;
    issue(1'b0, 2'b01, 1'b0, 32'h80000002, 32'h0);
    lat = 1;
    checks++; if ({wb_sel_o, done_o} !== 5'b1100_0) begin failures++; $display("FAIL lh_sel got=%b exp=11000", {wb_sel_o, done_o}); end
    wb_ack_i = 1'b1; wb_dat_i = 32'h80017FFF;
    while (!done_o && lat < 10) begin
      tick();
      wb_ack_i = 1'b0;
      lat++;
    end
    checks++; if (lat !== 2) begin failures++; $display("FAIL lh_latency got=%0d exp=2", lat); end
    checks++; if (rdata_o !== 32'hFFFF8001) begin failures++; $display("FAIL lh_rdata got=%h exp=ffff8001", rdata_o); end
    tick();
  endtask

  task automatic test_store();
    issue(1'b1, 2'b00, 1'b0, 32'h80000001, 32'h000000AB);
    checks++; if (wb_dat_o[15:8] !== 8'hAB) begin failures++; $display("FAIL sb_dat got=%h exp=ab", wb_dat_o[15:8]); end
    checks++; if ({wb_sel_o, wb_we_o, wb_cyc_o} !== 6'b0010_11) begin failures++; $display("FAIL sb_ctl got=%b exp=001011", {wb_sel_o, wb_we_o, wb_cyc_o}); end
    ack_with(32'hFFFFFFFF);
    checks++; if ({done_o, rdata_o} !== 33'h1_0000_0000) begin failures++; $display("FAIL sb_done got=%b/%h exp=1/0", done_o, rdata_o); end
    tick();
    issue(1'b1, 2'b10, 1'b0, 32'h80000004, 32'hDEADBEEF);
    checks++; if ({wb_sel_o, wb_dat_o, wb_adr_o} !== {4'hF, 32'hDEADBEEF, 32'h80000004}) begin failures++; $display("FAIL sw_bus got=%h/%h/%h exp=f/deadbeef/80000004", wb_sel_o, wb_dat_o, wb_adr_o); end
    ack_with(32'h0);
    checks++; if ({done_o, rdata_o} !== 33'h1_0000_0000) begin failures++; $display("FAIL sw_done got=%b/%h exp=1/0", done_o, rdata_o); end
    tick();
  endtask

  task automatic test_misalign();
    issue(1'b0, 2'b10, 1'b0, 32'h80000008, 32'h0);
    ack_with(32'h12345678);
    checks++; if ({done_o, rdata_o} !== 33'h1_12345678) begin failures++; $display("FAIL lw_rdata got=%b/%h exp=1/12345678", done_o, rdata_o); end
    tick();
    for (int s = 0; s < 2; s++) begin
      issue(1'b0, s ? 2'b11 : 2'b10, 1'b0, s ? 32'h80000000 : 32'h80000002, 32'h0);
      checks++; if ({done_o, misalign_o, wb_cyc_o, wb_stb_o} !== 4'b1100) begin failures++; $display("FAIL mis_done s=%0d got=%b exp=1100", s, {done_o, misalign_o, wb_cyc_o, wb_stb_o}); end
      checks++; if (rdata_o !== 32'h0) begin failures++; $display("FAIL mis_rdata s=%0d got=%h exp=0", s, rdata_o); end
      tick();
      checks++; if ({done_o, wb_cyc_o, req_ready_o} !== 3'b001) begin failures++; $display("FAIL mis_after s=%0d got=%b exp=001", s, {done_o, wb_cyc_o, req_ready_o}); end
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h80000010, 32'h0);
    checks++; if (wb_cyc_o !== 1'b1) begin failures++; $display("FAIL rmid_cyc got=%b exp=1", wb_cyc_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if ({wb_cyc_o, wb_stb_o, req_ready_o, done_o} !== 4'b0010) begin failures++; $display("FAIL rmid_state got=%b exp=0010", {wb_cyc_o, wb_stb_o, req_ready_o, done_o}); end
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen_done |= done_o | wb_cyc_o;
    end
    wb_ack_i = 1'b0;
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL rmid_late_ack got=%b exp=0", seen_done); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] dn = '0, rdy = '0, cyc = '0;
    req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b1;
    req_addr_i = 32'h80000000; wb_dat_i = 32'h000000A5; req_valid_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      dn[c] = done_o; rdy[c] = req_ready_o; cyc[c] = wb_cyc_o;
      wb_ack_i = wb_cyc_o;
    end
    req_valid_i = 1'b0; wb_ack_i = 1'b0;
    checks++; if (dn !== 9'b100100100) begin failures++; $display("FAIL b2b_done got=%b exp=100100100", dn); end
    checks++; if (rdy !== 9'b001001000) begin failures++; $display("FAIL b2b_ready got=%b exp=001001000", rdy); end
    checks++; if (cyc !== 9'b010010010) begin failures++; $display("FAIL b2b_cyc got=%b exp=010010010", cyc); end
    checks++; if (rdata_o !== 32'h000000A5) begin failures++; $display("FAIL b2b_rdata got=%h exp=000000a5", rdata_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lh();
    test_store();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory stage of the multi-cycle CPU. It takes one load/store request from the execute/control path and runs a single Wishbone classic-cycle master transaction. It aligns store data and byte selects, then extracts and sign- or zero-extends load data. Its rdata_o is the memory input of the register-writeback select stage.

Parameters:
ADDR_WIDTH, 32, address width of request and Wishbone bus
DATA_WIDTH, 32, data width; fixed 32, byte-lane logic assumes 4 lanes

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset
req_valid_i  input  1  request present
req_ready_o  output  1  unit idle, can accept request
req_we_i  input  1  1=store, 0=load
req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  input  1  zero-extend loads (lbu/lhu)
req_addr_i  input  ADDR_WIDTH  byte address
req_wdata_i  input  DATA_WIDTH  store data, right-aligned
done_o  output  1  one-cycle completion pulse
misalign_o  output  1  valid with done_o; request rejected, no bus cycle
rdata_o  output  DATA_WIDTH  extended load data, valid from done_o until next done_o
wb_cyc_o  output  1  Wishbone cycle
wb_stb_o  output  1  Wishbone strobe
wb_ack_i  input  1  Wishbone acknowledge
wb_adr_o  output  ADDR_WIDTH  word-aligned address
wb_dat_o  output  DATA_WIDTH  lane-aligned store data
wb_dat_i  input  DATA_WIDTH  read data
wb_sel_o  output  4  byte enables
wb_we_o  output  1  write enable

Behaviour:
- Clocking and reset: single clock clk_i. rst_i is synchronous and active-high.
- Reset values: state IDLE; req_ready_o=1; done_o, misalign_o, wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o, wb_dat_o, wb_sel_o, rdata_o = 0.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered except req_ready_o, which is 1 only in IDLE.
- IDLE: on req_valid_i && req_ready_o, latch all req_* fields.
  - Misaligned request goes to DONE with no bus activity. Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - Otherwise go to ACCESS and assert cyc, stb and we (we = req_we_i) on the next cycle.
- Bus fields, driven from the latched request:
  - wb_adr_o = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - wb_sel_o: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - wb_dat_o = wdata << (8*addr[1:0]). Lanes outside sel are don't-care.
- ACCESS: hold cyc, stb, adr, sel, dat and we stable until wb_ack_i=1.
  - On the ack edge, capture wb_dat_i, drop cyc/stb (0 next cycle) and go to DONE.
- DONE: done_o=1 for exactly one cycle; misalign_o reflects the latched flag. Return to IDLE the next cycle.
- rdata_o for loads: select lane (dat_i >> 8*addr[1:0]), take 8/16/32 bits, sign-extend unless unsigned.
  - Store or misaligned: rdata_o=0.
  - rdata_o holds its value until the next DONE.
- Latency: request accepted at edge 0; stb high during cycle 1. Ack seen at edge k (k≥1) gives done_o high during cycle k+1. Minimum accept-to-done is 2 cycles; misaligned is 1 cycle.
- Back-to-back: a new request can be accepted the cycle after done_o (IDLE). No request is accepted while busy; req_valid_i is ignored outside IDLE.
- wb_ack_i outside ACCESS is ignored.
- Reset mid-transaction: the transaction is abandoned. cyc/stb are 0 after the reset edge, no done_o pulse is produced, and the request is lost.
- No error/retry/stall signals. A slave that never acks hangs the unit (no timeout).

Test Plan:
- lb addr 0x80000003, ack after 2 wait cycles with dat_i 0x80FF1234 -> sel 4'b1000, adr 0x80000000, we 0; rdata_o 0xFFFFFF80, done_o one cycle; same access with unsigned=1 -> rdata_o 0x00000080.
- lh addr 0x80000002, immediate ack, dat_i 0x80017FFF -> sel 4'b1100; rdata_o 0xFFFF8001; done_o exactly 2 cycles after accept.
- sb addr 0x80000001, wdata 0x000000AB -> wb_dat_o[15:8]=0xAB, sel 4'b0010, we 1; rdata_o 0 on done. sw 0x80000004, wdata 0xDEADBEEF -> sel 4'hF, dat_o 0xDEADBEEF.
- lw addr 0x80000002 -> wb_cyc_o never asserts; done_o and misalign_o high 1 cycle after accept; size 11 -> same.
- rst_i asserted while in ACCESS (before ack) -> cyc/stb 0 next cycle, req_ready_o 1, no done_o; a late wb_ack_i is ignored.
- Two back-to-back loads with req_valid_i held high -> second accepted the cycle after first done_o; req_valid_i ignored while busy; each load yields exactly one done_o.
